// File: rtl/imem_fetch_ctrl_if.sv
// Loader stream and IF-stage fetch bundle for imem_fetch_ctrl.
// fetch_fault exists only when IMEM_BOUNDS_CHECK_EN is defined.
interface imem_fetch_ctrl_if #(
    parameter int unsigned DEPTH = 64
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic          load_valid;
    logic          load_ready;
    logic [31:0]   load_data;
    logic          load_last;
    logic          load_start;
    logic          fetch_req;
    logic [31:0]   fetch_pc;
    logic [31:0]   instruction;
    logic          inst_valid;
    logic          cpu_stall;
    logic [AW:0]   load_count;
`ifdef IMEM_BOUNDS_CHECK_EN
    logic          fetch_fault;
`endif

    modport master (
        output load_valid, load_data, load_last, load_start, fetch_req, fetch_pc,
        input  load_ready, instruction, inst_valid, cpu_stall, load_count
`ifdef IMEM_BOUNDS_CHECK_EN
        , input fetch_fault
`endif
    );

    modport slave (
        input  load_valid, load_data, load_last, load_start, fetch_req, fetch_pc,
        output load_ready, instruction, inst_valid, cpu_stall, load_count
`ifdef IMEM_BOUNDS_CHECK_EN
        , output fetch_fault
`endif
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Loadable instruction RAM: accepts a program, NOP-fills the tail, then serves fetches.
// Optional out-of-range fetch detection with sticky fault: IMEM_BOUNDS_CHECK_EN.
module imem_fetch_ctrl #(
    parameter int unsigned DEPTH    = 64,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    imem_fetch_ctrl_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {ST_LOAD, ST_CLEAR, ST_RUN} state_e;

    state_e          state_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [CW-1:0]   load_count_q;
    logic            load_ready_q;
    logic            cpu_stall_q;
    logic            inst_valid_q;
    logic [31:0]     instruction_q;
    logic [31:0]     mem [DEPTH];

    logic            accept_c;
    logic            mem_we_c;
    logic [31:0]     mem_wdata_c;
    logic [AW-1:0]   rd_addr_c;
    logic            oob_c;
    logic            unused_c;

    always_comb begin
        accept_c    = (state_q == ST_LOAD) && bus.load_valid && load_ready_q;
        mem_we_c    = accept_c || (state_q == ST_CLEAR);
        mem_wdata_c = (state_q == ST_CLEAR) ? NOP_WORD : bus.load_data;
        rd_addr_c   = bus.fetch_pc[AW+1:2];
`ifdef IMEM_BOUNDS_CHECK_EN
        oob_c       = |bus.fetch_pc[31:AW+2];
        unused_c    = ^bus.fetch_pc[1:0];
`else
        oob_c       = 1'b0;
        unused_c    = ^{bus.fetch_pc[31:AW+2], bus.fetch_pc[1:0]};
`endif
    end

    // RAM has no reset: contents survive rst and are rewritten by the next load
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[wr_ptr_q] <= mem_wdata_c;
        end
    end

`ifdef IMEM_BOUNDS_CHECK_EN
    logic fetch_fault_q;
    assign bus.fetch_fault = fetch_fault_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_LOAD;
            wr_ptr_q      <= '0;
            load_count_q  <= '0;
            load_ready_q  <= 1'b0;
            cpu_stall_q   <= 1'b1;
            inst_valid_q  <= 1'b0;
            instruction_q <= NOP_WORD;
`ifdef IMEM_BOUNDS_CHECK_EN
            fetch_fault_q <= 1'b0;
`endif
        end else begin
            inst_valid_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    load_ready_q <= 1'b1;
                    if (accept_c) begin
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                        if (load_count_q < CW'(DEPTH)) begin
                            load_count_q <= load_count_q + CW'(1);
                        end
                        // Last slot filled: nothing left to NOP-fill
                        if (wr_ptr_q == AW'(DEPTH - 1)) begin
                            state_q      <= ST_RUN;
                            cpu_stall_q  <= 1'b0;
                            load_ready_q <= 1'b0;
                        end else if (bus.load_last) begin
                            state_q      <= ST_CLEAR;
                            load_ready_q <= 1'b0;
                        end
                    end
                end
                ST_CLEAR: begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                    if (wr_ptr_q == AW'(DEPTH - 1)) begin
                        state_q     <= ST_RUN;
                        cpu_stall_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bus.fetch_req) begin
                        inst_valid_q  <= 1'b1;
                        instruction_q <= oob_c ? NOP_WORD : mem[rd_addr_c];
`ifdef IMEM_BOUNDS_CHECK_EN
                        if (oob_c) fetch_fault_q <= 1'b1;
`endif
                    end
                    // Reload still lets this cycle's fetch complete
                    if (bus.load_start) begin
                        state_q      <= ST_LOAD;
                        wr_ptr_q     <= '0;
                        load_count_q <= '0;
                        cpu_stall_q  <= 1'b1;
                        load_ready_q <= 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
                        fetch_fault_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign bus.load_ready  = load_ready_q;
    assign bus.cpu_stall   = cpu_stall_q;
    assign bus.inst_valid  = inst_valid_q;
    assign bus.instruction = instruction_q;
    assign bus.load_count  = load_count_q;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: fetch vector table plus load/reload/reset sequences.
// Expectations for the bounds-check feature follow IMEM_BOUNDS_CHECK_EN.
module tb_imem_fetch_ctrl;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic [31:0] exp;
    } fvec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_fetch_ctrl_if #(.DEPTH(DEPTH)) bus ();
    imem_fetch_ctrl #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb_q [$];
    fvec_t       tab [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_stall"}, 32'(bus.cpu_stall), 32'd1);
        chk({nm, "_ready"}, 32'(bus.load_ready), 32'd0);
        chk({nm, "_ivalid"}, 32'(bus.inst_valid), 32'd0);
        chk({nm, "_instr"}, bus.instruction, NOP);
        chk({nm, "_count"}, 32'(bus.load_count), 32'd0);
`ifdef IMEM_BOUNDS_CHECK_EN
        chk({nm, "_fault"}, 32'(bus.fetch_fault), 32'd0);
`endif
    endtask

    // Hold the word until the DUT accepts it, bounded
    task automatic load_word(input logic [31:0] d, input logic last);
        bit   ok;
        logic rdy;
        ok = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_last  = last;
        for (int t = 0; t < 16 && !ok; t++) begin
            rdy = bus.load_ready;
            tick();
            if (rdy) ok = 1'b1;
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL load_accept: word %h not accepted, expected accept", d);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        logic [31:0] got;
        for (int i = lo; i < hi; i++) begin
            bus.fetch_req = tab[i].req;
            bus.fetch_pc  = tab[i].pc;
            if (tab[i].req) sb_q.push_back(tab[i].exp);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(bus.inst_valid), 32'(tab[i].req));
            if (tab[i].req) begin
                if (sb_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL vec%0d_sb: got empty scoreboard expected entry", i);
                end else begin
                    got = sb_q.pop_front();
                    chk($sformatf("vec%0d_instr", i), bus.instruction, got);
                end
            end else begin
                chk($sformatf("vec%0d_hold", i), bus.instruction, tab[i].exp);
            end
        end
        bus.fetch_req = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [31:0] got;

        tab[0]  = '{1'b1, 32'h0000_0004, 32'h0010_8113};
        tab[1]  = '{1'b1, 32'h0000_0010, NOP};
        tab[2]  = '{1'b1, 32'h0000_0000, 32'h0010_0093};
        tab[3]  = '{1'b0, 32'h0000_0008, 32'h0010_0093};
        tab[4]  = '{1'b1, 32'h0000_000B, 32'h0020_81b3};
        tab[5]  = '{1'b1, 32'h0000_00FC, NOP};
        tab[6]  = '{1'b1, 32'h0000_00FC, 32'hA000_003F};
        tab[7]  = '{1'b1, 32'h0000_0050, 32'hA000_0014};
        tab[8]  = '{1'b1, 32'h0000_004C, 32'hA000_0013};
        tab[9]  = '{1'b1, 32'h0000_0054, 32'hA000_0015};
        tab[10] = '{1'b0, 32'h0000_0000, 32'hA000_0015};
`ifdef IMEM_BOUNDS_CHECK_EN
        tab[11] = '{1'b1, 32'h0000_0100, NOP};
`else
        tab[11] = '{1'b1, 32'h0000_0100, 32'hA000_0000};
`endif
        tab[12] = '{1'b1, 32'h0000_0008, 32'hA000_0002};

        rst            = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bus.load_start = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_pc   = '0;
        repeat (3) tick();
        chk_reset_vals("rst_hold");
        rst = 1'b0;
        chk_reset_vals("rst_release");
        tick();
        chk("ready_after_rst", 32'(bus.load_ready), 32'd1);

        // Short load: last word at index 2, RUN at T+62
        load_word(32'h0010_0093, 1'b0);
        load_word(32'h0010_8113, 1'b0);
        load_word(32'h0020_81b3, 1'b1);
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        chk("short_ready_drop", 32'(bus.load_ready), 32'd0);
        chk("short_stall_clear", 32'(bus.cpu_stall), 32'd1);
        cnt = 1;
        while (bus.cpu_stall && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("short_run_cycle", 32'(cnt), 32'd62);
        chk("short_count", 32'(bus.load_count), 32'd3);
        run_vecs(0, 6);

        // Reload with a concurrent fetch
        bus.load_start = 1'b1;
        bus.fetch_req  = 1'b1;
        bus.fetch_pc   = 32'h8;
        sb_q.push_back(32'h0020_81b3);
        tick();
        bus.load_start = 1'b0;
        bus.fetch_req  = 1'b0;
        chk("reload_fetch_valid", 32'(bus.inst_valid), 32'd1);
        got = sb_q.pop_front();
        chk("reload_fetch_instr", bus.instruction, got);
        chk("reload_stall", 32'(bus.cpu_stall), 32'd1);
        chk("reload_count", 32'(bus.load_count), 32'd0);
        chk("reload_ready_n1", 32'(bus.load_ready), 32'd0);
        tick();
        chk("reload_ready_n2", 32'(bus.load_ready), 32'd1);

        // Full load with a 5-cycle loader stall at index 20
        for (int i = 0; i < 64; i++) begin
            if (i == 20) begin
                bus.load_valid = 1'b0;
                bus.load_data  = 32'hDEAD_BEEF;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk($sformatf("stall_count%0d", s), 32'(bus.load_count), 32'd20);
                end
            end
            load_word(32'hA000_0000 + 32'(i), 1'b0);
        end
        bus.load_valid = 1'b0;
        chk("full_run_next", 32'(bus.cpu_stall), 32'd0);
        chk("full_count", 32'(bus.load_count), 32'd64);
        chk("full_ready_drop", 32'(bus.load_ready), 32'd0);
        run_vecs(6, 13);
`ifdef IMEM_BOUNDS_CHECK_EN
        chk("fault_sticky", 32'(bus.fetch_fault), 32'd1);
`endif

        // Reload clears fault, then reset mid-load
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        chk("reload2_stall", 32'(bus.cpu_stall), 32'd1);
`ifdef IMEM_BOUNDS_CHECK_EN
        chk("reload2_fault_clr", 32'(bus.fetch_fault), 32'd0);
`endif
        tick();
        load_word(32'h1111_1111, 1'b0);
        load_word(32'h2222_2222, 1'b0);
        chk("midload_count", 32'(bus.load_count), 32'd2);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_midload");
        bus.load_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("ready_after_rst2", 32'(bus.load_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
